// File: rtl/display_base_converter_seq.sv
`default_nettype none
// ============================================================================
// Module      : display_base_converter_seq
// Description : Converts an unsigned value into N_DIGITS active-low
//               seven-segment patterns (decimal via iterative double-dabble,
//               hexadecimal or octal). Supports leading-zero blanking,
//               overflow dashes and a registered display enable, all behind
//               a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module display_base_converter_seq #(
  parameter int DATA_W   = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value,
  input  logic [1:0]            base_sel,
  input  logic                  lzb_en,
  input  logic                  start,
  input  logic                  show_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*N_DIGITS-1:0] segs
);

  // Number of decimal digits needed for the largest DATA_W-bit value.
  function automatic int nb_calc(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v / 10;
    end
    return n;
  endfunction

  // Active-low gfedcba glyph for one nibble.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  localparam int NB    = nb_calc(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int VX_W  = DATA_W + 4 * N_DIGITS;
  localparam int BX_W  = 4 * (NB + N_DIGITS);

  localparam logic [1:0] C_BASE_BLANK = 2'b00;
  localparam logic [1:0] C_BASE_HEX   = 2'b01;
  localparam logic [1:0] C_BASE_OCT   = 2'b10;
  localparam logic [1:0] C_BASE_DEC   = 2'b11;

  localparam logic [6:0] C_SEG_BLANK = 7'h7F;
  localparam logic [6:0] C_SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DEC_SHIFT = 2'd1,
    S_LATCH     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       val_q, val_d;
  logic [4*NB-1:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              base_q, base_d;
  logic                    lzb_q, lzb_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [7*N_DIGITS-1:0]   pat_q, pat_d;
  logic                    show_en_q;

  logic [4*NB-1:0]         w_adj;
  logic [VX_W-1:0]         w_val_ext;
  logic [BX_W-1:0]         w_bcd_ext;
  logic [3:0]              w_nib [N_DIGITS];
  logic                    w_ovf;
  logic [7*N_DIGITS-1:0]   w_pat;
  logic                    w_nz;

  // Zero-extend so digit positions beyond the value width read as 0.
  assign w_val_ext = {{(4*N_DIGITS){1'b0}}, val_q};
  assign w_bcd_ext = {{(4*N_DIGITS){1'b0}}, bcd_q};

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    w_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Per-digit nibble extraction and overflow detection for the captured base.
  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_nib[i] = 4'h0;
    end
    case (base_q)
      C_BASE_DEC: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          w_nib[i] = w_bcd_ext[4*i +: 4];
        end
        w_ovf = |(w_bcd_ext >> (4 * N_DIGITS));
      end
      C_BASE_HEX: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          w_nib[i] = w_val_ext[4*i +: 4];
        end
        w_ovf = |(w_val_ext >> (4 * N_DIGITS));
      end
      C_BASE_OCT: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          w_nib[i] = {1'b0, w_val_ext[3*i +: 3]};
        end
        w_ovf = |(w_val_ext >> (3 * N_DIGITS));
      end
      default: begin
        w_ovf = 1'b0;
      end
    endcase
  end

  // Glyph selection, scanning from the top digit so w_nz tracks whether any
  // nonzero digit exists at or above the current position.
  always_comb begin
    w_pat = '1;
    w_nz  = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_nz = w_nz | (|w_nib[i]);
      if (base_q == C_BASE_BLANK) begin
        w_pat[7*i +: 7] = C_SEG_BLANK;
      end else if (w_ovf) begin
        w_pat[7*i +: 7] = C_SEG_DASH;
      end else if (lzb_q && (i != 0) && !w_nz) begin
        w_pat[7*i +: 7] = C_SEG_BLANK;
      end else begin
        w_pat[7*i +: 7] = glyph(w_nib[i]);
      end
    end
  end

  // Next-state logic for the conversion FSM and its datapath.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    lzb_d   = lzb_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    pat_d   = pat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          val_d  = value;
          base_d = base_sel;
          lzb_d  = lzb_en;
          if (base_sel == C_BASE_DEC) begin
            bcd_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
            state_d = S_DEC_SHIFT;
          end else begin
            state_d = S_LATCH;
          end
        end
      end
      S_DEC_SHIFT: begin
        {bcd_d, val_d} = {w_adj, val_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        pat_d   = w_pat;
        ovf_d   = w_ovf;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      base_q  <= C_BASE_BLANK;
      lzb_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pat_q   <= '1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      lzb_q   <= lzb_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      pat_q   <= pat_d;
    end
  end

  // Display enable is sampled every cycle, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      show_en_q <= 1'b0;
    end else begin
      show_en_q <= show_en;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign segs = show_en_q ? pat_q : '1;

endmodule
`default_nettype wire

// File: tb/tb_display_base_converter_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_base_converter_seq
// Description : Self-checking bench for display_base_converter_seq with a
//               3-digit and a 2-digit instance sharing the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_base_converter_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  value = '0;
  logic [1:0]  base_sel = '0;
  logic        lzb_en = 1'b0;
  logic        start = 1'b0;
  logic        show_en = 1'b0;
  logic        busy, done, ovf;
  logic [20:0] segs;
  logic        busy2, done2, ovf2;
  logic [13:0] segs2;

  int checks = 0;
  int errors = 0;

  display_base_converter_seq #(.DATA_W(8), .N_DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .base_sel(base_sel),
    .lzb_en(lzb_en), .start(start), .show_en(show_en),
    .busy(busy), .done(done), .ovf(ovf), .segs(segs)
  );

  display_base_converter_seq #(.DATA_W(8), .N_DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .value(value), .base_sel(base_sel),
    .lzb_en(lzb_en), .start(start), .show_en(show_en),
    .busy(busy2), .done(done2), .ovf(ovf2), .segs(segs2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ref_glyph(input int d);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[d];
  endfunction

  // Reference display from plain radix arithmetic.
  function automatic logic [41:0] model(input int v, input int b, input bit lz,
                                        input int nd, output bit ov);
    logic [41:0] s;
    int r;
    int p;
    s  = '1;
    ov = 1'b0;
    if (b == 0) return s;
    r = (b == 3) ? 10 : ((b == 1) ? 16 : 8);
    p = 1;
    for (int k = 0; k < nd; k++) p = p * r;
    if (v >= p) begin
      ov = 1'b1;
      for (int i = 0; i < nd; i++) s[7*i +: 7] = 7'h3F;
      return s;
    end
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (lz && i > 0 && (v / p) == 0) s[7*i +: 7] = 7'h7F;
      else s[7*i +: 7] = ref_glyph((v / p) % r);
      p = p * r;
    end
    return s;
  endfunction

  // Issue one start and wait (bounded) for done; lat counts edges after T0.
  task automatic run_conv(input int v, input int b, input bit lz,
                          output int lat, output int busy_cyc);
    value    = v[7:0];
    base_sel = b[1:0];
    lzb_en   = lz;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cyc++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (segs !== 21'h1FFFFF) begin errors++; $display("FAIL reset_segs got %h want 1fffff", segs); end
    checks++; if (segs2 !== 14'h3FFF) begin errors++; $display("FAIL reset_segs2 got %h want 3fff", segs2); end
    tick();
    rst_n   = 1'b1;
    show_en = 1'b1;
    tick();
  endtask

  task automatic test_decimal;
    int lat, bc;
    run_conv(237, 3, 1'b0, lat, bc);
    checks++; if (lat != 9) begin errors++; $display("FAIL dec_latency got %0d want 9", lat); end
    checks++; if (bc != 9) begin errors++; $display("FAIL dec_busy_cycles got %0d want 9", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec_busy_at_done got %b want 0", busy); end
    checks++; if (segs !== {7'h24, 7'h30, 7'h78}) begin errors++; $display("FAIL dec_237_segs got %h want %h", segs, {7'h24, 7'h30, 7'h78}); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dec_237_ovf got %b want 0", ovf); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dec_done_pulse got %b want 0", done); end
  endtask

  task automatic test_hex;
    int lat, bc;
    run_conv(8'hA7, 1, 1'b1, lat, bc);
    checks++; if (lat != 1) begin errors++; $display("FAIL hex_latency got %0d want 1", lat); end
    checks++; if (segs !== {7'h7F, 7'h08, 7'h78}) begin errors++; $display("FAIL hex_a7_segs got %h want %h", segs, {7'h7F, 7'h08, 7'h78}); end
  endtask

  task automatic test_octal;
    int lat, bc;
    run_conv(255, 2, 1'b1, lat, bc);
    checks++; if (segs !== {7'h30, 7'h78, 7'h78}) begin errors++; $display("FAIL oct_377_segs got %h want %h", segs, {7'h30, 7'h78, 7'h78}); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL oct_377_ovf got %b want 0", ovf); end
    run_conv(5, 2, 1'b1, lat, bc);
    checks++; if (segs !== {7'h7F, 7'h7F, 7'h12}) begin errors++; $display("FAIL oct_5_segs got %h want %h", segs, {7'h7F, 7'h7F, 7'h12}); end
    run_conv(0, 3, 1'b1, lat, bc);
    checks++; if (segs !== {7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL dec_zero_lzb got %h want %h", segs, {7'h7F, 7'h7F, 7'h40}); end
  endtask

  task automatic test_overflow;
    int lat, bc;
    run_conv(150, 3, 1'b0, lat, bc);
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL ovf_done2 got %b want 1", done2); end
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_150_flag got %b want 1", ovf2); end
    checks++; if (segs2 !== {7'h3F, 7'h3F}) begin errors++; $display("FAIL ovf_150_segs got %h want %h", segs2, {7'h3F, 7'h3F}); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_150_wide got %b want 0", ovf); end
    run_conv(99, 3, 1'b0, lat, bc);
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_99_flag got %b want 0", ovf2); end
    checks++; if (segs2 !== {7'h10, 7'h10}) begin errors++; $display("FAIL ovf_99_segs got %h want %h", segs2, {7'h10, 7'h10}); end
    run_conv(8'hFF, 2, 1'b0, lat, bc);
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_oct_flag got %b want 1", ovf2); end
  endtask

  task automatic test_blank;
    int lat, bc;
    run_conv(123, 0, 1'b0, lat, bc);
    checks++; if (lat != 1) begin errors++; $display("FAIL blank_latency got %0d want 1", lat); end
    checks++; if (segs !== 21'h1FFFFF) begin errors++; $display("FAIL blank_segs got %h want 1fffff", segs); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL blank_ovf got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    run_conv(8'h3C, 1, 1'b0, lat, bc);
    run_conv(201, 3, 1'b0, lat, bc);
    checks++; if (lat != 9) begin errors++; $display("FAIL b2b_latency got %0d want 9", lat); end
    checks++; if (segs !== {7'h24, 7'h40, 7'h79}) begin errors++; $display("FAIL b2b_segs got %h want %h", segs, {7'h24, 7'h40, 7'h79}); end
  endtask

  task automatic test_ignore_start;
    int lat, dcount;
    logic [20:0] prev;
    prev     = segs;
    value    = 8'd46;
    base_sel = 2'b11;
    lzb_en   = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick(); tick();
    checks++; if (segs !== prev) begin errors++; $display("FAIL hold_segs_midconv got %h want %h", segs, prev); end
    value    = 8'hFF;
    base_sel = 2'b01;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 3;
    while (done !== 1'b1 && lat < 200) begin tick(); lat++; end
    checks++; if (lat != 9) begin errors++; $display("FAIL ignore_latency got %0d want 9", lat); end
    checks++; if (segs !== {7'h40, 7'h19, 7'h02}) begin errors++; $display("FAIL ignore_segs got %h want %h", segs, {7'h40, 7'h19, 7'h02}); end
    dcount = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (done === 1'b1) dcount++; end
    checks++; if (dcount != 0) begin errors++; $display("FAIL ignore_extra_done got %0d want 0", dcount); end
  endtask

  task automatic test_show_en;
    int lat, bc;
    run_conv(237, 3, 1'b0, lat, bc);
    show_en = 1'b0;
    #2;
    checks++; if (segs !== {7'h24, 7'h30, 7'h78}) begin errors++; $display("FAIL show_before_edge got %h want %h", segs, {7'h24, 7'h30, 7'h78}); end
    tick();
    checks++; if (segs !== 21'h1FFFFF) begin errors++; $display("FAIL show_off got %h want 1fffff", segs); end
    show_en = 1'b1;
    tick();
    checks++; if (segs !== {7'h24, 7'h30, 7'h78}) begin errors++; $display("FAIL show_restore got %h want %h", segs, {7'h24, 7'h30, 7'h78}); end
  endtask

  task automatic test_random;
    int lat, bc, v, b;
    bit lz, ov3, ov2;
    logic [41:0] e3, e2;
    for (int n = 0; n < 40; n++) begin
      v  = $urandom_range(0, 255);
      b  = $urandom_range(0, 3);
      lz = 1'($urandom_range(0, 1));
      e3 = model(v, b, lz, 3, ov3);
      e2 = model(v, b, lz, 2, ov2);
      run_conv(v, b, lz, lat, bc);
      checks++; if (lat != ((b == 3) ? 9 : 1)) begin errors++; $display("FAIL rnd_latency v=%0d b=%0d got %0d", v, b, lat); end
      checks++; if (segs !== e3[20:0] || ovf !== ov3) begin errors++; $display("FAIL rnd_n3 v=%0d b=%0d lz=%0d got %h/%b want %h/%b", v, b, lz, segs, ovf, e3[20:0], ov3); end
      checks++; if (segs2 !== e2[13:0] || ovf2 !== ov2) begin errors++; $display("FAIL rnd_n2 v=%0d b=%0d lz=%0d got %h/%b want %h/%b", v, b, lz, segs2, ovf2, e2[13:0], ov2); end
    end
  endtask

  task automatic test_reset_abort;
    int dcount;
    value    = 8'd200;
    base_sel = 2'b11;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (segs !== 21'h1FFFFF) begin errors++; $display("FAIL abort_segs got %h want 1fffff", segs); end
    tick();
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (done === 1'b1) dcount++; end
    checks++; if (dcount != 0) begin errors++; $display("FAIL abort_done got %0d want 0", dcount); end
    checks++; if (segs !== 21'h1FFFFF) begin errors++; $display("FAIL abort_digits_cleared got %h want 1fffff", segs); end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_octal();
    test_overflow();
    test_blank();
    test_back_to_back();
    test_ignore_start();
    test_show_en();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
